frame_clear_scheduler: RTL and testbench



---
 rtl/frame_clear_scheduler.sv | 197 +++++++++++++++++++
 tb/tb_frame_clear_scheduler.sv | 286 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/frame_clear_scheduler.sv
// Frame-start sequencer: drains DDR bursts, clears the pixel FIFO, settles, then opens writes into ping-pong banks.
// Optional FRAME_CLEAR_STATS_EN adds saturating drop_cnt / ok_cnt frame statistics outputs.
//
// state      | meaning
// IDLE       | after reset, FIFO held in clear, waiting for first frame start
// WAIT_BURST | frame start seen, letting the in-flight DDR burst finish
// CLEAR      | pixel FIFO clear asserted for CLR_CYCLES
// SETTLE     | quiet gap of SETTLE_CYCLES before writes open
// RUN        | write path open, counting frame words
// DONE       | full frame landed, waiting for next frame start
module frame_clear_scheduler #(
    parameter int                CLR_CYCLES    = 8,
    parameter int                SETTLE_CYCLES = 16,
    parameter int                FRAME_WORDS   = 307200,
    parameter int                CNT_W         = 20,
    parameter int                ADDR_W        = 28,
    parameter logic [ADDR_W-1:0] BANK0_BASE    = 28'h0000000,
    parameter logic [ADDR_W-1:0] BANK1_BASE    = 28'h0100000
) (
    input  logic              clock_target,
    input  logic              rst_n,
    input  logic              clear_req_target,
    input  logic              burst_busy,
    input  logic              wr_word_valid,
    output logic              fifo_clear,
    output logic              wr_enable,
    output logic [ADDR_W-1:0] wr_base_addr,
    output logic              bank_sel,
    output logic              rd_bank,
    output logic              frame_done,
    output logic              frame_err
`ifdef FRAME_CLEAR_STATS_EN
    ,
    output logic [15:0]       drop_cnt,
    output logic [15:0]       ok_cnt
`endif
);

    localparam int PH_MAX = (CLR_CYCLES > SETTLE_CYCLES) ? CLR_CYCLES : SETTLE_CYCLES;
    localparam int PH_W   = $clog2(PH_MAX + 1);

    localparam logic [PH_W-1:0]  CLR_LAST    = PH_W'(CLR_CYCLES - 1);
    localparam logic [PH_W-1:0]  SETTLE_LAST = PH_W'(SETTLE_CYCLES - 1);
    localparam logic [PH_W-1:0]  PH_ONE      = PH_W'(1);
    localparam logic [CNT_W-1:0] CNT_LAST    = CNT_W'(FRAME_WORDS - 1);
    localparam logic [CNT_W-1:0] CNT_ONE     = CNT_W'(1);

    typedef enum logic [2:0] {
        IDLE       = 3'd0,
        WAIT_BURST = 3'd1,
        CLEAR      = 3'd2,
        SETTLE     = 3'd3,
        RUN        = 3'd4,
        DONE       = 3'd5
    } state_t;

    state_t            state_q, state_d;
    logic [PH_W-1:0]   phase_q, phase_d;
    logic [CNT_W-1:0]  word_cnt_q, word_cnt_d;
    logic              bank_sel_d;
    logic              rd_bank_d;
    logic              fifo_clear_d;
    logic              wr_enable_d;
    logic              frame_done_d;
    logic              frame_err_d;
    logic [ADDR_W-1:0] wr_base_addr_d;
    logic              req_ignored;

    always_ff @(posedge clock_target or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        phase_d      = phase_q;
        word_cnt_d   = word_cnt_q;
        bank_sel_d   = bank_sel;
        rd_bank_d    = rd_bank;
        frame_done_d = 1'b0;
        frame_err_d  = 1'b0;
        req_ignored  = 1'b0;

        case (state_q)
            IDLE: begin
                if (clear_req_target) begin
                    state_d = WAIT_BURST;
                end
            end
            WAIT_BURST: begin
                req_ignored = clear_req_target;
                if (!burst_busy) begin
                    state_d    = CLEAR;
                    phase_d    = '0;
                    word_cnt_d = '0;
                end
            end
            CLEAR: begin
                req_ignored = clear_req_target;
                if (phase_q == CLR_LAST) begin
                    state_d = SETTLE;
                    phase_d = '0;
                end else begin
                    phase_d = phase_q + PH_ONE;
                end
            end
            SETTLE: begin
                req_ignored = clear_req_target;
                if (phase_q == SETTLE_LAST) begin
                    state_d = RUN;
                    phase_d = '0;
                end else begin
                    phase_d = phase_q + PH_ONE;
                end
            end
            RUN: begin
                // A final word arriving with the next frame start still completes the frame
                if (wr_word_valid && (word_cnt_q == CNT_LAST)) begin
                    word_cnt_d   = word_cnt_q + CNT_ONE;
                    frame_done_d = 1'b1;
                    rd_bank_d    = bank_sel;
                    if (clear_req_target) begin
                        bank_sel_d = ~bank_sel;
                        state_d    = WAIT_BURST;
                    end else begin
                        state_d = DONE;
                    end
                end else if (clear_req_target) begin
                    frame_err_d = 1'b1;
                    state_d     = WAIT_BURST;
                end else if (wr_word_valid) begin
                    word_cnt_d = word_cnt_q + CNT_ONE;
                end
            end
            DONE: begin
                if (clear_req_target) begin
                    bank_sel_d = ~bank_sel;
                    state_d    = WAIT_BURST;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // fifo_clear trails CLEAR by one cycle but drops on the very edge a req leaves IDLE
        fifo_clear_d   = (state_d == IDLE) || (state_q == CLEAR);
        wr_enable_d    = (state_q == RUN) && (state_d == RUN);
        wr_base_addr_d = bank_sel_d ? BANK1_BASE : BANK0_BASE;
    end

    always_ff @(posedge clock_target or negedge rst_n) begin
        if (!rst_n) begin
            phase_q      <= '0;
            word_cnt_q   <= '0;
            fifo_clear   <= 1'b1;
            wr_enable    <= 1'b0;
            bank_sel     <= 1'b0;
            rd_bank      <= 1'b0;
            wr_base_addr <= BANK0_BASE;
            frame_done   <= 1'b0;
            frame_err    <= 1'b0;
        end else begin
            phase_q      <= phase_d;
            word_cnt_q   <= word_cnt_d;
            fifo_clear   <= fifo_clear_d;
            wr_enable    <= wr_enable_d;
            bank_sel     <= bank_sel_d;
            rd_bank      <= rd_bank_d;
            wr_base_addr <= wr_base_addr_d;
            frame_done   <= frame_done_d;
            frame_err    <= frame_err_d;
        end
    end

`ifdef FRAME_CLEAR_STATS_EN
    always_ff @(posedge clock_target or negedge rst_n) begin
        if (!rst_n) begin
            drop_cnt <= '0;
            ok_cnt   <= '0;
        end else begin
            if ((frame_err_d || req_ignored) && (drop_cnt != 16'hFFFF)) begin
                drop_cnt <= drop_cnt + 16'd1;
            end
            if (frame_done_d && (ok_cnt != 16'hFFFF)) begin
                ok_cnt <= ok_cnt + 16'd1;
            end
        end
    end
`else
    // Without statistics, ignored requests are simply dropped with no record
`endif

endmodule

// File: tb/tb_frame_clear_scheduler.sv
// Scoreboard bench for frame_clear_scheduler: expected output events are queued as stimulus is driven
// and matched against edges seen on the DUT outputs. Builds with or without FRAME_CLEAR_STATS_EN.
module tb_frame_clear_scheduler;

    localparam int          CLR  = 8;
    localparam int          SET  = 16;
    localparam int          FW   = 40;
    localparam int          AW   = 28;
    localparam logic [27:0] B0   = 28'h0000000;
    localparam logic [27:0] B1   = 28'h0100000;

    // event kinds seen by the monitor
    localparam int EV_FC_RISE = 1;
    localparam int EV_FC_FALL = 2;
    localparam int EV_WE_RISE = 3;
    localparam int EV_WE_FALL = 4;
    localparam int EV_DONE    = 5;
    localparam int EV_ERR     = 6;

    // pre-events expected on the req edge itself
    localparam int PRE_NONE  = 0;
    localparam int PRE_IDLE  = 1;
    localparam int PRE_ABORT = 2;
    localparam int PRE_FULL  = 3;

    logic          clock_target = 1'b0;
    logic          rst_n = 1'b0;
    logic          clear_req_target = 1'b0;
    logic          burst_busy = 1'b0;
    logic          wr_word_valid = 1'b0;
    logic          fifo_clear;
    logic          wr_enable;
    logic [AW-1:0] wr_base_addr;
    logic          bank_sel;
    logic          rd_bank;
    logic          frame_done;
    logic          frame_err;
`ifdef FRAME_CLEAR_STATS_EN
    logic [15:0]   drop_cnt;
    logic [15:0]   ok_cnt;
`endif

    frame_clear_scheduler #(
        .CLR_CYCLES   (CLR),
        .SETTLE_CYCLES(SET),
        .FRAME_WORDS  (FW),
        .CNT_W        (20),
        .ADDR_W       (AW),
        .BANK0_BASE   (B0),
        .BANK1_BASE   (B1)
    ) dut (
        .clock_target    (clock_target),
        .rst_n           (rst_n),
        .clear_req_target(clear_req_target),
        .burst_busy      (burst_busy),
        .wr_word_valid   (wr_word_valid),
        .fifo_clear      (fifo_clear),
        .wr_enable       (wr_enable),
        .wr_base_addr    (wr_base_addr),
        .bank_sel        (bank_sel),
        .rd_bank         (rd_bank),
        .frame_done      (frame_done),
        .frame_err       (frame_err)
`ifdef FRAME_CLEAR_STATS_EN
        ,
        .drop_cnt        (drop_cnt),
        .ok_cnt          (ok_cnt)
`endif
    );

    always #5 clock_target = ~clock_target;

    typedef struct {
        int kind;
        int cyc;
    } ev_t;

    ev_t  exp_q[$];
    int   cyc = 0;
    int   n_vec = 0;
    int   n_err = 0;
    logic prev_fc = 1'b1;
    logic prev_we = 1'b0;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    task automatic expect_ev(input int kind, input int c);
        exp_q.push_back('{kind: kind, cyc: c});
    endtask

    task automatic sb_event(input int kind);
        ev_t e;
        if (exp_q.size() == 0) begin
            check_val("unexpected_event", kind, 0);
        end else begin
            e = exp_q.pop_front();
            check_val("event_kind", kind, e.kind);
            check_val("event_cycle", cyc, e.cyc);
        end
    endtask

    // Cycle k is the interval after the k-th rising edge; outputs sampled 1 time unit after it
    always @(posedge clock_target) begin
        cyc = cyc + 1;
        #1;
        if (fifo_clear && !prev_fc) sb_event(EV_FC_RISE);
        if (!fifo_clear && prev_fc) sb_event(EV_FC_FALL);
        if (wr_enable && !prev_we)  sb_event(EV_WE_RISE);
        if (!wr_enable && prev_we)  sb_event(EV_WE_FALL);
        if (frame_done)             sb_event(EV_DONE);
        if (frame_err)              sb_event(EV_ERR);
        prev_fc = fifo_clear;
        prev_we = wr_enable;
    end

    task automatic tick(input int n);
        repeat (n) @(negedge clock_target);
    endtask

    // Issue one req at the current negedge; busy holds burst_busy for that many cycles from the req
    task automatic req_seq(input int pre, input int busy, input bit expect_run, output int t);
        int r;
        clear_req_target = 1'b1;
        if (busy > 0) burst_busy = 1'b1;
        t = cyc + 1;
        case (pre)
            PRE_IDLE:  expect_ev(EV_FC_FALL, t);
            PRE_ABORT: begin expect_ev(EV_WE_FALL, t); expect_ev(EV_ERR, t); end
            PRE_FULL:  begin expect_ev(EV_WE_FALL, t); expect_ev(EV_DONE, t); end
            default:   ;
        endcase
        r = t + 2 + ((busy > 0) ? (busy - 1) : 0);
        expect_ev(EV_FC_RISE, r);
        expect_ev(EV_FC_FALL, r + CLR);
        if (expect_run) expect_ev(EV_WE_RISE, r + CLR + SET);
        tick(1);
        clear_req_target = 1'b0;
        wr_word_valid    = 1'b0;
        if (busy > 0) begin
            tick(busy - 1);
            burst_busy = 1'b0;
        end
    endtask

    task automatic wait_we(output int d);
        bit seen;
        seen = 1'b0;
        d    = -1;
        for (int i = 0; i < 200 && !seen; i++) begin
            if (wr_enable) begin
                seen = 1'b1;
                d    = cyc;
            end else begin
                tick(1);
            end
        end
        if (!seen) check_val("wr_enable_timeout", 0, 1);
    endtask

    task automatic feed(input int n);
        for (int i = 0; i < n; i++) begin
            wr_word_valid = 1'b1;
            tick(1);
        end
        wr_word_valid = 1'b0;
    endtask

    initial begin
        int t;
        int d;

        tick(3);
        rst_n = 1'b1;
        tick(20);
        check_val("rst_fifo_clear", fifo_clear, 1);
        check_val("rst_wr_enable", wr_enable, 0);
        check_val("rst_bank_sel", bank_sel, 0);
        check_val("rst_wr_base_addr", wr_base_addr, B0);
        check_val("rst_rd_bank", rd_bank, 0);
        check_val("rst_frame_done", frame_done, 0);
        check_val("rst_frame_err", frame_err, 0);
`ifdef FRAME_CLEAR_STATS_EN
        check_val("rst_drop_cnt", drop_cnt, 0);
        check_val("rst_ok_cnt", ok_cnt, 0);
`endif

        // first frame from IDLE, no burst pending, full frame into bank 0
        req_seq(PRE_IDLE, 0, 1'b1, t);
        check_val("idle_req_bank_sel", bank_sel, 0);
        wait_we(d);
        check_val("wr_enable_latency", d, t + 2 + CLR + SET);
        expect_ev(EV_WE_FALL, d + FW);
        expect_ev(EV_DONE, d + FW);
        feed(FW);
        check_val("full_rd_bank", rd_bank, 0);
        check_val("full_bank_sel_held", bank_sel, 0);
        tick(2);
        feed(3);
        tick(2);
`ifdef FRAME_CLEAR_STATS_EN
        check_val("full_ok_cnt", ok_cnt, 1);
`endif

        // next frame from DONE with a 5-cycle burst draining: bank flips to 1
        req_seq(PRE_NONE, 5, 1'b1, t);
        check_val("toggle_bank_sel", bank_sel, 1);
        check_val("toggle_wr_base_addr", wr_base_addr, B1);
        check_val("toggle_rd_bank", rd_bank, 0);

        // short frame of 10 words aborted by req: same bank rewritten
        wait_we(d);
        feed(10);
        req_seq(PRE_ABORT, 0, 1'b1, t);
        check_val("short_bank_sel", bank_sel, 1);
        check_val("short_rd_bank", rd_bank, 0);
        check_val("short_wr_base_addr", wr_base_addr, B1);
`ifdef FRAME_CLEAR_STATS_EN
        check_val("short_drop_cnt", drop_cnt, 1);
        check_val("short_ok_cnt", ok_cnt, 1);
`endif

        // final word coincides with req: frame completes and bank flips back
        wait_we(d);
        feed(FW - 1);
        wr_word_valid = 1'b1;
        req_seq(PRE_FULL, 0, 1'b1, t);
        check_val("coinc_bank_sel", bank_sel, 0);
        check_val("coinc_rd_bank", rd_bank, 1);
        check_val("coinc_wr_base_addr", wr_base_addr, B0);
`ifdef FRAME_CLEAR_STATS_EN
        check_val("coinc_ok_cnt", ok_cnt, 2);
`endif

        // abort, second req 3 cycles later is ignored, then reset lands in SETTLE
        wait_we(d);
        req_seq(PRE_ABORT, 0, 1'b0, t);
        tick(2);
        clear_req_target = 1'b1;
        tick(1);
        clear_req_target = 1'b0;
        tick(11);
`ifdef FRAME_CLEAR_STATS_EN
        check_val("ignored_drop_cnt", drop_cnt, 3);
`endif
        tick(1);
        rst_n = 1'b0;
        expect_ev(EV_FC_RISE, cyc + 1);
        tick(1);
        check_val("midrst_fifo_clear", fifo_clear, 1);
        check_val("midrst_wr_enable", wr_enable, 0);
        check_val("midrst_bank_sel", bank_sel, 0);
        check_val("midrst_rd_bank", rd_bank, 0);
        check_val("midrst_wr_base_addr", wr_base_addr, B0);
`ifdef FRAME_CLEAR_STATS_EN
        check_val("midrst_drop_cnt", drop_cnt, 0);
        check_val("midrst_ok_cnt", ok_cnt, 0);
`endif
        tick(3);
        rst_n = 1'b1;
        tick(40);
        check_val("post_rst_fifo_clear", fifo_clear, 1);

        // sequencer restarts cleanly from IDLE
        req_seq(PRE_IDLE, 0, 1'b1, t);
        wait_we(d);
        check_val("post_rst_we_latency", d, t + 2 + CLR + SET);
        tick(3);
        check_val("scoreboard_drained", exp_q.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation still running at cycle %0d, expected finish", cyc);
        $fatal(1, "watchdog expired");
    end

endmodule
